// File: rtl/dht_multi_reader.sv
// -----------------------------------------------------------------------------
// dht_multi_reader
//   Scans N_CH DHT11/DHT22-style single-wire sensors one after another. For
//   each channel: pull the line low for the start pulse, release it, follow
//   the sensor's response handshake, shift in 40 bits (MSB first, bit value
//   from the high-time width) and report one result per channel through a
//   valid/ready port.
//
//   Optional build macro: DHT_RETRY_EN -- a channel that ends in error is
//   retried once after a 1000 us released gap; only the retry result is shown.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              single-cycle scan request (ignored while busy)
//   busy               high from scan acceptance until the last result is taken
//   dht_in[N_CH]       raw line levels (asynchronous, synchronized inside)
//   dht_drive_low[N_CH] 1 = pull the line low (open-drain), 0 = release
//   out_valid/out_ready result handshake
//   out_ch             channel index of the result
//   out_data           {hum_int, hum_dec, temp_int, temp_dec}
//   out_err            0 ok, 1 no response, 2 data timeout, 3 checksum
// -----------------------------------------------------------------------------
module dht_multi_reader #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int N_CH          = 4,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 100,
  parameter int BIT_THRESH_US = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  input  logic [N_CH-1:0] dht_in,
  output logic [N_CH-1:0] dht_drive_low,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_ch,
  output logic [31:0]     out_data,
  output logic [1:0]      out_err
);

  localparam int DIV          = CLK_FREQ_HZ / 1000000;
  localparam int DIV_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RETRY_GAP_US = 1000;
  localparam int T_MAX0       = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int T_MAX        = (T_MAX0 > RETRY_GAP_US) ? T_MAX0 : RETRY_GAP_US;
  localparam int TMR_W        = $clog2(T_MAX + 2);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH,
    BIT_LOW, BIT_HIGH, CHECK, OUTPUT
`ifdef DHT_RETRY_EN
    , RETRY_WAIT
`endif
  } state_t;

  state_t             state;
  logic [N_CH-1:0]    sync1, sync2;
  logic [2:0]         ch;
  logic [DIV_W-1:0]   div;
  logic [TMR_W-1:0]   timer;
  logic [39:0]        shreg;
  logic [5:0]         bit_cnt;
  logic               seen_high;
`ifdef DHT_RETRY_EN
  logic               retried;
`endif

  logic [7:0]         line_pad;
  logic               cur_line;
  logic               tick;
  logic               timeout;
  logic [7:0]         sum;
  logic [1:0]         fail_code;

  assign out_ch  = ch;
  assign tick    = (div == DIV_W'(DIV - 1));
  assign timeout = tick && (timer == TMR_W'(TIMEOUT_US));
  assign sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  // Pad the synchronized lines to 8 bits so the 3-bit channel index always
  // selects a real bit, whatever N_CH is.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    line_pad = '0;
    line_pad[N_CH-1:0] = sync2;
  end
  assign cur_line = line_pad[ch];

  // Error raised by the current phase; the timeout class depends on whether
  // the sensor ever answered (handshake) or stalled mid-data.
  always_comb begin
    fail_code = 2'd0;
    case (state)
      WAIT_RESP, RESP_LOW, RESP_HIGH: if (timeout) fail_code = 2'd1;
      BIT_LOW, BIT_HIGH:              if (timeout) fail_code = 2'd2;
      CHECK:                          if (sum != shreg[7:0]) fail_code = 2'd3;
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments, so every right-hand
  // side sees the pre-edge value and later assignments simply override the
  // timebase defaults below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync1         <= '0;
      sync2         <= '0;
      ch            <= '0;
      div           <= '0;
      timer         <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
      seen_high     <= 1'b0;
      busy          <= 1'b0;
      dht_drive_low <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_err       <= '0;
`ifdef DHT_RETRY_EN
      retried       <= 1'b0;
`endif
    end else begin
      sync1 <= dht_in;
      sync2 <= sync1;

      // 1 us timebase; phase timers count ticks and restart on each transition.
      if (tick) begin
        div   <= '0;
        timer <= timer + TMR_W'(1);
      end else begin
        div   <= div + DIV_W'(1);
      end

`ifdef DHT_RETRY_EN
      if (fail_code != 2'd0 && !retried) begin
        retried <= 1'b1;
        state   <= RETRY_WAIT;
        div     <= '0;
        timer   <= '0;
      end else
`endif
      if (fail_code != 2'd0) begin
        state     <= OUTPUT;
        out_valid <= 1'b1;
        out_err   <= fail_code;
        out_data  <= (fail_code == 2'd3) ? shreg[39:8] : 32'd0;
      end else begin
        case (state)
          IDLE: begin
            div   <= '0;
            timer <= '0;
            if (start) begin
              busy          <= 1'b1;
              ch            <= 3'd0;
              dht_drive_low <= N_CH'(1);
              state         <= START_LOW;
`ifdef DHT_RETRY_EN
              retried       <= 1'b0;
`endif
            end
          end
          START_LOW: begin
            if (tick && timer == TMR_W'(START_LOW_US - 1)) begin
              dht_drive_low <= '0;
              seen_high     <= 1'b0;
              state         <= WAIT_RESP;
              div           <= '0;
              timer         <= '0;
            end
          end
          // The synchronizer still shows our own drive for two cycles after
          // release, so a low only counts once the line has been seen high.
          WAIT_RESP: begin
            if (cur_line) begin
              seen_high <= 1'b1;
            end else if (seen_high) begin
              state <= RESP_LOW;
              div   <= '0;
              timer <= '0;
            end
          end
          RESP_LOW: begin
            if (cur_line) begin
              state <= RESP_HIGH;
              div   <= '0;
              timer <= '0;
            end
          end
          RESP_HIGH: begin
            if (!cur_line) begin
              bit_cnt <= '0;
              state   <= BIT_LOW;
              div     <= '0;
              timer   <= '0;
            end
          end
          BIT_LOW: begin
            if (cur_line) begin
              state <= BIT_HIGH;
              div   <= '0;
              timer <= '0;
            end
          end
          BIT_HIGH: begin
            if (!cur_line) begin
              shreg   <= {shreg[38:0], (timer > TMR_W'(BIT_THRESH_US))};
              bit_cnt <= bit_cnt + 6'd1;
              state   <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
              div     <= '0;
              timer   <= '0;
            end
          end
          CHECK: begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_err   <= 2'd0;
            out_data  <= shreg[39:8];
          end
          OUTPUT: begin
            div   <= '0;
            timer <= '0;
            if (out_ready) begin
              out_valid <= 1'b0;
              if (ch == 3'(N_CH - 1)) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                ch            <= ch + 3'd1;
                dht_drive_low <= N_CH'(1) << (ch + 3'd1);
                state         <= START_LOW;
`ifdef DHT_RETRY_EN
                retried       <= 1'b0;
`endif
              end
            end
          end
`ifdef DHT_RETRY_EN
          RETRY_WAIT: begin
            if (tick && timer == TMR_W'(RETRY_GAP_US - 1)) begin
              dht_drive_low <= N_CH'(1) << ch;
              state         <= START_LOW;
              div           <= '0;
              timer         <= '0;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dht_multi_reader.md
DHT_MULTI_READER -- requirements
Module: dht_multi_reader

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, giving the clk frequency; it SHALL be an integer multiple of 1000000.
REQ-002 SHALL have parameter N_CH, default 4, giving the number of sensor lines (1..8).
REQ-003 SHALL have parameter START_LOW_US, default 18000, giving the host start-pulse low time.
REQ-004 SHALL have parameter TIMEOUT_US, default 100, giving the maximum time for any single sensor phase.
REQ-005 SHALL have parameter BIT_THRESH_US, default 40, as the high-time threshold separating bit 0 from bit 1.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle request to scan all channels.
REQ-009 busy  output  1  high from scan acceptance until the last channel result is taken.
REQ-010 dht_in  input  N_CH  raw sensor line levels (asynchronous).
REQ-011 dht_drive_low  output  N_CH  1 = pull line low (open-drain), 0 = release.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_ch  output  3  channel index of result.
REQ-015 out_data  output  32  {hum_int, hum_dec, temp_int, temp_dec}.
REQ-016 out_err  output  2  0 ok, 1 no response, 2 data timeout, 3 checksum.

Function
REQ-017 dht_in SHALL pass through a 2-flop synchronizer per channel; all decisions use the synchronized value.
REQ-018 A 1 us tick SHALL be generated every CLK_FREQ_HZ/1000000 clk cycles; all phase timers count ticks.
REQ-019 start in IDLE SHALL begin a scan at channel 0; start while busy SHALL be ignored.
REQ-020 FSM states: IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, OUTPUT.
REQ-021 START_LOW: drive the current channel low for START_LOW_US ticks, then release and go to WAIT_RESP.
REQ-022 WAIT_RESP/RESP_LOW/RESP_HIGH: wait for line low, then high, then low, each within TIMEOUT_US; on overrun go to OUTPUT with err=1.
REQ-023 BIT_LOW waits for high; BIT_HIGH measures high time until the falling edge; high > BIT_THRESH_US -> 1, else 0; overrun in either state -> OUTPUT with err=2.
REQ-024 40 bits SHALL be shifted in MSB first; the 40th bit ends on its falling edge and goes to CHECK.
REQ-025 CHECK: err=3 if byte4 != (byte0+byte1+byte2+byte3) mod 256, else err=0; out_data = bytes 0..3 regardless of err; 1-cycle state.
REQ-026 OUTPUT: out_valid=1 with out_ch/out_data/out_err stable until the cycle out_valid&&out_ready; then the next channel -> START_LOW, or after channel N_CH-1 -> IDLE with busy=0 in the following cycle.
REQ-027 On error, out_data SHALL be 0 for err 1 and 2.
REQ-028 At most one dht_drive_low bit SHALL be high at any time, and only in START_LOW.
REQ-029 The channel index SHALL wrap to 0 only at scan start, never mid-scan.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, dht_drive_low=0, busy=0, out_valid=0, out_ch=0, out_data=0, out_err=0, and clear the tick, timers and shift register.
REQ-031 Reset mid-transaction SHALL release all lines in the same cycle (asynchronous), with no result emitted.

Configuration
REQ-032 Macro DHT_RETRY_EN defined: a channel ending with err!=0 SHALL be retried once (back to START_LOW after 1000 ticks released); only the retry result is output.
REQ-033 Macro DHT_RETRY_EN undefined: no retry; the first-attempt result is output.

Verification
REQ-034 CLK_FREQ_HZ=1000000, N_CH=2, sensor models sending 0x37 0x00 0x18 0x00 0x4F, start -> two results ch0, ch1 with out_data=0x37001800, err=0, busy falls after the second accept.
REQ-035 Channel 1 never responds -> ch0 ok, ch1 err=1 at ~START_LOW_US+101 ticks (no macro); with DHT_RETRY_EN, err=1 after the second attempt.
REQ-036 Checksum byte 0x50 instead of 0x4F -> err=3, out_data=0x37001800.
REQ-037 Hold out_ready=0 for 500 cycles -> out_valid and fields stable, no next-channel drive, accept -> next channel START_LOW.
REQ-038 Assert rst_n=0 during bit 20 of ch0 -> dht_drive_low=0, out_valid=0, busy=0 immediately; start re-issued -> clean full scan.
REQ-039 start pulses during busy -> ignored, exactly N_CH results per scan.
